inputc: RTL and testbench

Router input-port stage feeding the crossbar's per-input `idata_N/ivalid_N/ivch_N/port_N/req_N` and consuming `grt_N`/`fwdab_N`. Buffers incoming flits in per-VC FIFOs, performs XY route computation on head flits, round-robin selects one VC per cycle, and requests the crossbar output port. Returns one credit per dequeued flit to the upstream router.

---
 rtl/inputc.sv | 179 +++++++++++++++++
 tb/tb_inputc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/inputc.sv
// Router input port: per-VC flit FIFOs, XY route computation on head flits,
// round-robin VC selection with hold-while-ungranted, and credit return upstream.
module inputc #(
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int DEPTH    = 4,
  parameter int DATAW    = 31,
  parameter int VCHW     = 1,
  parameter int PORT     = 4,
  parameter int PORTW    = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW:0]   idata,
  input  logic             ivalid,
  input  logic [VCHW:0]    ivch,
  input  logic [PORT:0]    oready,
  input  logic [PORT:0]    grt,
  output logic [DATAW:0]   odata,
  output logic             ovalid,
  output logic [VCHW:0]    ovch,
  output logic [PORTW:0]   port,
  output logic             req,
  output logic             fwdab,
  output logic             ocredit,
  output logic [VCHW:0]    ocredit_vch,
  output logic             ovf
);

  localparam int NVC = 1 << (VCHW + 1);
  localparam int VCW = VCHW + 1;
  localparam int PW  = PORTW + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [DATAW:0] mem       [NVC][DEPTH];
  logic [AW-1:0]  rd_ptr    [NVC];
  logic [AW-1:0]  wr_ptr    [NVC];
  logic [CW-1:0]  cnt       [NVC];
  logic [0:0]     vstate    [NVC];
  logic [PW-1:0]  vroute    [NVC];
  logic [DATAW:0] front     [NVC];
  logic [PW-1:0]  route_eff [NVC];

  logic [NVC-1:0] elig;
  logic [NVC-1:0] has_tail;
  logic [NVC-1:0] wr_en;
  logic [NVC-1:0] rd_en;

  logic [VCW-1:0] rr_ptr;
  logic [VCW-1:0] held_vc;
  logic           held_vld;
  logic [VCW-1:0] sel_vc;
  logic           sel_vld;
  logic           deq;
  logic           wr_ok;

  function automatic logic [PW-1:0] xy_route(input logic [7:0] dst);
    logic [PW-1:0] r;
    if (dst[7:4] > 4'(ROUTER_X))      r = PW'(1);
    else if (dst[7:4] < 4'(ROUTER_X)) r = PW'(3);
    else if (dst[3:0] > 4'(ROUTER_Y)) r = PW'(2);
    else if (dst[3:0] < 4'(ROUTER_Y)) r = PW'(0);
    else                              r = PW'(4);
    return r;
  endfunction

  function automatic logic port_bit(input logic [PORT:0] vec, input logic [PW-1:0] p);
    logic b;
    b = 1'b0;
    for (int k = 0; k <= PORT; k++)
      if (p == PW'(k)) b = vec[k];
    return b;
  endfunction

  // Per-VC front flit, effective route, eligibility and tail presence
  always_comb begin
    front     = '{default: '0};
    route_eff = '{default: '0};
    elig      = '0;
    has_tail  = '0;
    for (int v = 0; v < NVC; v++) begin
      front[v]     = mem[v][rd_ptr[v]];
      route_eff[v] = (vstate[v] == S_ACTIVE) ? vroute[v] : xy_route(front[v][7:0]);
      // an IDLE VC only moves when a head (01/11) is at the front
      elig[v]      = (cnt[v] != '0) && ((vstate[v] == S_ACTIVE) || front[v][DATAW-1])
                     && port_bit(oready, route_eff[v]);
      for (int i = 0; i < DEPTH; i++)
        if ((CW'(i) < cnt[v]) && mem[v][rd_ptr[v] + AW'(i)][DATAW])
          has_tail[v] = 1'b1;
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_vc  = '0;
    if (held_vld && elig[held_vc]) begin
      sel_vld = 1'b1;
      sel_vc  = held_vc;
    end else begin
      for (int i = 0; i < NVC; i++) begin
        if (!sel_vld && elig[rr_ptr + VCW'(i)]) begin
          sel_vld = 1'b1;
          sel_vc  = rr_ptr + VCW'(i);
        end
      end
    end
  end

  assign req    = sel_vld;
  assign ovalid = sel_vld;
  assign ovch   = sel_vld ? sel_vc : '0;
  assign port   = sel_vld ? route_eff[sel_vc] : '0;
  assign odata  = sel_vld ? front[sel_vc] : '0;
  assign fwdab  = sel_vld && has_tail[sel_vc];

  assign deq   = sel_vld && port_bit(grt, route_eff[sel_vc]);
  assign wr_ok = ivalid && ((cnt[ivch] != CW'(DEPTH)) || (deq && (sel_vc == ivch)));

  always_comb begin
    wr_en = '0;
    rd_en = '0;
    for (int v = 0; v < NVC; v++) begin
      wr_en[v] = wr_ok && (ivch == VCW'(v));
      rd_en[v] = deq && (sel_vc == VCW'(v));
    end
  end

  // Flit storage: data only, no reset
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[ivch][wr_ptr[ivch]] <= idata;
  end

  // Control state: pointers, counts, VC state, arbitration, credit, overflow
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        cnt[v]    <= '0;
        vstate[v] <= S_IDLE;
        vroute[v] <= '0;
      end
      rr_ptr      <= '0;
      held_vc     <= '0;
      held_vld    <= 1'b0;
      ocredit     <= 1'b0;
      ocredit_vch <= '0;
      ovf         <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (rd_en[v]) begin
          rd_ptr[v] <= rd_ptr[v] + 1'b1;
          case (front[v][DATAW:DATAW-1])
            2'b01: begin
              vstate[v] <= S_ACTIVE;
              vroute[v] <= route_eff[v];
            end
            2'b10:   vstate[v] <= S_IDLE;
            default: ;
          endcase
        end
        cnt[v] <= cnt[v] + {{AW{1'b0}}, wr_en[v]} - {{AW{1'b0}}, rd_en[v]};
      end
      if (deq) rr_ptr <= sel_vc + 1'b1;
      held_vld    <= sel_vld && !deq;
      held_vc     <= sel_vc;
      ocredit     <= deq;
      ocredit_vch <= deq ? sel_vc : '0;
      ovf         <= ovf | (ivalid && !wr_ok);
    end
  end

endmodule

// File: tb/tb_inputc.sv
// Directed vector bench for inputc at router (1,1), DEPTH=4.
module tb_inputc;

  logic        clk;
  logic        rst_;
  logic [31:0] idata;
  logic        ivalid;
  logic [1:0]  ivch;
  logic [4:0]  oready;
  logic [4:0]  grt;
  logic [31:0] odata;
  logic        ovalid;
  logic [1:0]  ovch;
  logic [2:0]  port;
  logic        req;
  logic        fwdab;
  logic        ocredit;
  logic [1:0]  ocredit_vch;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  inputc #(.ROUTER_X(1), .ROUTER_Y(1), .DEPTH(4)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .oready(oready), .grt(grt), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .port(port), .req(req), .fwdab(fwdab), .ocredit(ocredit),
    .ocredit_vch(ocredit_vch), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  ivc;
    logic [31:0] idat;
    logic [4:0]  ordy;
    logic [4:0]  g;
    logic        rq;
    logic [2:0]  prt;
    logic [1:0]  ovc;
    logic        fwd;
    logic [31:0] od;
    logic        cr;
    logic [1:0]  crvc;
    logic        of;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] fl(logic [1:0] t, logic [3:0] dx, logic [3:0] dy, logic [7:0] tag);
    return {t, 14'h0, tag, dx, dy};
  endfunction

  function automatic vec_t v(int iv, int ivc, logic [31:0] idat, int ordy, int g,
                             int rq, int prt, int ovc, int fwd, logic [31:0] od,
                             int cr, int crvc, int of);
    vec_t r;
    r.iv = 1'(iv);    r.ivc = 2'(ivc);  r.idat = idat; r.ordy = 5'(ordy); r.g = 5'(g);
    r.rq = 1'(rq);    r.prt = 3'(prt);  r.ovc = 2'(ovc); r.fwd = 1'(fwd); r.od = od;
    r.cr = 1'(cr);    r.crvc = 2'(crvc); r.of = 1'(of);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(string tag, logic rq, logic [2:0] prt, logic [1:0] ovc, logic fwd,
                          logic [31:0] od, logic cr, logic [1:0] crvc, logic of);
    chk({tag, ".req"},    32'(req),         32'(rq));
    chk({tag, ".ovalid"}, 32'(ovalid),      32'(rq));
    chk({tag, ".port"},   32'(port),        32'(prt));
    chk({tag, ".ovch"},   32'(ovch),        32'(ovc));
    chk({tag, ".fwdab"},  32'(fwdab),       32'(fwd));
    chk({tag, ".odata"},  odata,            od);
    chk({tag, ".ocred"},  32'(ocredit),     32'(cr));
    chk({tag, ".ocvch"},  32'(ocredit_vch), 32'(crvc));
    chk({tag, ".ovf"},    32'(ovf),         32'(of));
  endtask

  task automatic drive(logic iv, logic [1:0] ivc, logic [31:0] idat, logic [4:0] ordy, logic [4:0] g);
    ivalid = iv; ivch = ivc; idata = idat; oready = ordy; grt = g;
  endtask

  logic [31:0] f_a, f_h, f_b, f_t, f_p2a, f_p2b, f_p2c, f_p2d, f_x, f_y1, f_y2, f_y3;
  logic [31:0] f_p [1:6];
  logic [31:0] f_h1, f_b1, f_h2;

  initial begin
    f_a   = fl(2'b11, 4'd2, 4'd1, 8'hA0);
    f_h   = fl(2'b01, 4'd1, 4'd1, 8'hB0);
    f_b   = fl(2'b00, 4'd0, 4'd0, 8'hB1);
    f_t   = fl(2'b10, 4'd0, 4'd0, 8'hB2);
    f_p2a = fl(2'b11, 4'd1, 4'd2, 8'hC0);
    f_p2b = fl(2'b11, 4'd1, 4'd2, 8'hC1);
    f_p2c = fl(2'b11, 4'd1, 4'd2, 8'hC2);
    f_p2d = fl(2'b11, 4'd1, 4'd2, 8'hC3);
    f_x   = fl(2'b11, 4'd2, 4'd1, 8'hD0);
    f_y1  = fl(2'b11, 4'd1, 4'd2, 8'hD1);
    f_y2  = fl(2'b11, 4'd1, 4'd2, 8'hD2);
    f_y3  = fl(2'b11, 4'd1, 4'd2, 8'hD3);
    for (int i = 1; i <= 6; i++) f_p[i] = fl(2'b11, 4'd1, 4'd1, 8'(8'hE0 + i));
    f_h1  = fl(2'b01, 4'd2, 4'd1, 8'hF0);
    f_b1  = fl(2'b00, 4'd0, 4'd0, 8'hF1);
    f_h2  = fl(2'b01, 4'd1, 4'd2, 8'hF2);

    // head+tail to east, single grant, credit next cycle
    tbl.push_back(v(1,0,f_a,  5'h1f,5'h00, 0,0,0,0,0,     0,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h02, 1,1,0,1,f_a,   0,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h00, 0,0,0,0,0,     1,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h00, 0,0,0,0,0,     0,0,0));
    // head/body/tail to local on VC1
    tbl.push_back(v(1,1,f_h,  5'h1f,5'h10, 0,0,0,0,0,     0,0,0));
    tbl.push_back(v(1,1,f_b,  5'h1f,5'h10, 1,4,1,0,f_h,   0,0,0));
    tbl.push_back(v(1,1,f_t,  5'h1f,5'h10, 1,4,1,0,f_b,   1,1,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h10, 1,4,1,1,f_t,   1,1,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h00, 0,0,0,0,0,     1,1,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h00, 0,0,0,0,0,     0,0,0));
    // two VCs to south, alternate under continuous grant
    tbl.push_back(v(1,0,f_p2a,5'h1f,5'h00, 0,0,0,0,0,     0,0,0));
    tbl.push_back(v(1,1,f_p2b,5'h1f,5'h00, 1,2,0,1,f_p2a, 0,0,0));
    tbl.push_back(v(1,0,f_p2c,5'h1f,5'h00, 1,2,0,1,f_p2a, 0,0,0));
    tbl.push_back(v(1,1,f_p2d,5'h1f,5'h00, 1,2,0,1,f_p2a, 0,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h1b, 1,2,0,1,f_p2a, 0,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h04, 1,2,0,1,f_p2a, 0,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h04, 1,2,1,1,f_p2b, 1,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h04, 1,2,0,1,f_p2c, 1,1,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h04, 1,2,1,1,f_p2d, 1,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h00, 0,0,0,0,0,     1,1,0));
    // hold while ungranted, then oready drop
    tbl.push_back(v(1,1,f_x,  5'h1f,5'h00, 0,0,0,0,0,     0,0,0));
    tbl.push_back(v(1,2,f_y1, 5'h1f,5'h00, 1,1,1,1,f_x,   0,0,0));
    tbl.push_back(v(1,2,f_y2, 5'h1f,5'h00, 1,1,1,1,f_x,   0,0,0));
    tbl.push_back(v(1,2,f_y3, 5'h1f,5'h00, 1,1,1,1,f_x,   0,0,0));
    tbl.push_back(v(0,0,0,    5'h1d,5'h00, 1,2,2,1,f_y1,  0,0,0));
    tbl.push_back(v(0,0,0,    5'h00,5'h00, 0,0,0,0,0,     0,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h06, 1,2,2,1,f_y1,  0,0,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h06, 1,1,1,1,f_x,   1,2,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h06, 1,2,2,1,f_y2,  1,1,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h06, 1,2,2,1,f_y3,  1,2,0));
    tbl.push_back(v(0,0,0,    5'h1f,5'h00, 0,0,0,0,0,     1,2,0));
    // overflow at DEPTH=4, then write-with-dequeue at full
    tbl.push_back(v(1,0,f_p[1],5'h1f,5'h00, 0,0,0,0,0,      0,0,0));
    tbl.push_back(v(1,0,f_p[2],5'h1f,5'h00, 1,4,0,1,f_p[1], 0,0,0));
    tbl.push_back(v(1,0,f_p[3],5'h1f,5'h00, 1,4,0,1,f_p[1], 0,0,0));
    tbl.push_back(v(1,0,f_p[4],5'h1f,5'h00, 1,4,0,1,f_p[1], 0,0,0));
    tbl.push_back(v(1,0,f_p[5],5'h1f,5'h00, 1,4,0,1,f_p[1], 0,0,0));
    tbl.push_back(v(1,0,f_p[6],5'h1f,5'h10, 1,4,0,1,f_p[1], 0,0,1));
    tbl.push_back(v(0,0,0,     5'h1f,5'h10, 1,4,0,1,f_p[2], 1,0,1));
    tbl.push_back(v(0,0,0,     5'h1f,5'h10, 1,4,0,1,f_p[3], 1,0,1));
    tbl.push_back(v(0,0,0,     5'h1f,5'h10, 1,4,0,1,f_p[4], 1,0,1));
    tbl.push_back(v(0,0,0,     5'h1f,5'h10, 1,4,0,1,f_p[6], 1,0,1));
    tbl.push_back(v(0,0,0,     5'h1f,5'h00, 0,0,0,0,0,      1,0,1));

    rst_ = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 5'h1f, 5'h00);
    repeat (2) @(negedge clk);
    #1 chk_outs("reset", 0, 3'd0, 2'd0, 0, 32'h0, 0, 2'd0, 0);
    @(negedge clk);
    rst_ = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      drive(tbl[r].iv, tbl[r].ivc, tbl[r].idat, tbl[r].ordy, tbl[r].g);
      #1 chk_outs($sformatf("row%0d", r), tbl[r].rq, tbl[r].prt, tbl[r].ovc, tbl[r].fwd,
                  tbl[r].od, tbl[r].cr, tbl[r].crvc, tbl[r].of);
    end

    // reset while VC0 is ACTIVE with a body buffered
    @(negedge clk);
    drive(1'b1, 2'd0, f_h1, 5'h1f, 5'h00);
    @(negedge clk);
    drive(1'b1, 2'd0, f_b1, 5'h1f, 5'h02);
    #1 chk_outs("mid.head", 1, 3'd1, 2'd0, 0, f_h1, 0, 2'd0, 1);
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 5'h1f, 5'h00);
    #1 chk_outs("mid.body", 1, 3'd1, 2'd0, 0, f_b1, 1, 2'd0, 1);
    rst_ = 1'b0;
    #1 chk_outs("mid.rst", 0, 3'd0, 2'd0, 0, 32'h0, 0, 2'd0, 0);
    @(negedge clk);
    #1 chk_outs("mid.rst2", 0, 3'd0, 2'd0, 0, 32'h0, 0, 2'd0, 0);
    rst_ = 1'b1;
    @(negedge clk);
    drive(1'b1, 2'd0, f_h2, 5'h1f, 5'h00);
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 5'h1f, 5'h00);
    #1 chk_outs("reroute", 1, 3'd2, 2'd0, 0, f_h2, 0, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
